// File: rtl/branch_ctl_arb.sv
// branch_ctl_arb: merges per-source branch resolutions through credited FIFOs
// into one registered branch-control channel, served round-robin.
module branch_ctl_arb #(
   parameter int NUM_REQS = 4,
   parameter int DEPTH    = 2,
   parameter int NW_WIDTH = 4,
   parameter int PC_BITS  = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQS-1:0]          in_valid,
   input  logic [NUM_REQS*NW_WIDTH-1:0] in_wid,
   input  logic [NUM_REQS-1:0]          in_taken,
   input  logic [NUM_REQS*PC_BITS-1:0]  in_dest,
   output logic [NUM_REQS-1:0]          in_ready,
   output logic                         out_valid,
   output logic [NW_WIDTH-1:0]          out_wid,
   output logic                         out_taken,
   output logic [PC_BITS-1:0]           out_dest,
   output logic [NUM_REQS-1:0]          overflow
);
   localparam int EW = NW_WIDTH + 1 + PC_BITS;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;

   logic [EW-1:0]       mem_q [NUM_REQS][DEPTH];
   logic [AW-1:0]       rd_ptr_q [NUM_REQS];
   logic [AW-1:0]       wr_ptr_q [NUM_REQS];
   logic [CW-1:0]       count_q [NUM_REQS];
   logic [CW-1:0]       count_d [NUM_REQS];
   logic [NUM_REQS-1:0] ready_q, ovf_q, push, pop, nonempty;
   logic [PW-1:0]       rr_q, gnt_idx, cand;
   logic                gnt_found, out_valid_q;
   logic [EW-1:0]       out_q;

   // candidates use pre-push counts, so a fresh push never bypasses to the output
   always_comb begin
      push = in_valid & ready_q;
      for (int i = 0; i < NUM_REQS; i++) nonempty[i] = count_q[i] != '0;
   end

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx = rr_q;
      cand = rr_q;
      pop = '0;
      for (int k = 1; k <= NUM_REQS; k++) begin
         cand = PW'((int'(rr_q) + k) % NUM_REQS);
         if (!gnt_found && nonempty[cand]) begin
            gnt_found = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_found) pop[gnt_idx] = 1'b1;
      for (int i = 0; i < NUM_REQS; i++) count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            count_q[i] <= '0;
         end
         ready_q <= '1;
         ovf_q <= '0;
         rr_q <= PW'(NUM_REQS - 1);
         out_valid_q <= 1'b0;
         out_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (push[i]) begin
               mem_q[i][wr_ptr_q[i]] <= {in_wid[i*NW_WIDTH +: NW_WIDTH], in_taken[i], in_dest[i*PC_BITS +: PC_BITS]};
               wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
            end
            if (pop[i]) rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
            count_q[i] <= count_d[i];
            ready_q[i] <= count_d[i] < CW'(DEPTH);
         end
         ovf_q <= ovf_q | (in_valid & ~ready_q);
         out_valid_q <= gnt_found;
         if (gnt_found) begin
            out_q <= mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
            rr_q <= gnt_idx;
         end
      end
   end

   assign in_ready = ready_q;
   assign overflow = ovf_q;
   assign out_valid = out_valid_q;
   assign {out_wid, out_taken, out_dest} = out_q;
endmodule

// File: doc/branch_ctl_arb.md
Name: branch_ctl_arb

Overview:
- Merges branch resolutions from NUM_REQS independent producers (ALU/branch lanes, one per issue slice) into the single branch-control channel consumed by the warp scheduler.
- Branch-control channels have no backpressure, so each producer is given a per-source FIFO, a registered ready (credit) signal, and a sticky overflow flag.
- Sources are served round-robin; the output is registered and delivers at most one branch per cycle.

Parameters:
- NUM_REQS, 4, number of producer ports (>=1).
- DEPTH, 2, entries per source FIFO (power of two, >=2).
- NW_WIDTH, from VX_gpu_pkg, warp-id width.
- PC_BITS, from VX_gpu_pkg, branch-target width.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_REQS  per-source branch-resolution strobe.
- in_wid  in  NUM_REQS*NW_WIDTH  per-source warp id; source i occupies slice i.
- in_taken  in  NUM_REQS  per-source taken flag.
- in_dest  in  NUM_REQS*PC_BITS  per-source branch target.
- in_ready  out  NUM_REQS  per-source credit: 1 means the FIFO accepts a push this cycle.
- out_valid  out  1  merged branch-control strobe to the scheduler.
- out_wid  out  NW_WIDTH  warp id of the delivered branch.
- out_taken  out  1  taken flag of the delivered branch.
- out_dest  out  PC_BITS  target of the delivered branch.
- overflow  out  NUM_REQS  sticky per-source flag: a push was dropped.

Behaviour:
- Reset values: out_valid=0, out_wid=0, out_taken=0, out_dest=0, overflow=0, all FIFOs empty, RR pointer=NUM_REQS-1 (source 0 has first priority), in_ready=all 1 in the cycle after reset deasserts.
- Reset asserted mid-operation discards all queued entries, and out_valid is 0 on the next cycle.
- Push: in_valid[i]&&in_ready[i] at edge t writes {wid,taken,dest} to FIFO i.
- in_ready[i] is registered and equals (count_i<DEPTH), computed from the post-edge count.
  - No same-cycle credit on a pop at full: a full FIFO shows in_ready=0 for the cycle, even if it pops.
- Drop: in_valid[i]&&!in_ready[i] leaves the FIFO unchanged and sets overflow[i]=1. overflow[i] clears only on reset.
- Arbitration, combinational each cycle:
  - Candidates are the non-empty FIFOs, evaluated on counts before this edge's pushes.
  - Grant = first candidate at index strictly after the RR pointer, wrapping modulo NUM_REQS.
  - On grant: pop that FIFO head, load it into the output register, set out_valid=1 next cycle, and RR pointer<=grant.
  - With no candidate: out_valid=0 next cycle, pointer holds, and out_wid/out_taken/out_dest hold their last values.
- Latency:
  - Push at edge t gives the earliest out_valid at cycle t+2: FIFO registered at t, arbitrated in cycle t+1, output registered at the t+1 edge.
  - No bypass path.
- Simultaneous push and pop on the same FIFO: count unchanged, both operations take effect.
- Pointers wrap modulo DEPTH.
- Ordering:
  - Per source, strict FIFO order.
  - Across sources, no ordering guarantee. Producers must not emit two branches for the same wid on different ports within the same issue window; this is a scheduler invariant and is not checked here.
- out_valid is a single-cycle pulse per entry with no ready; every granted entry is delivered exactly once.
- Throughput: one entry per cycle total. With k sources continuously non-empty, each is served once every k cycles.
- Count widths are $clog2(DEPTH+1); the pointer width is $clog2(NUM_REQS) (1 bit when NUM_REQS=1). The NUM_REQS=1 configuration degenerates to a FIFO plus output register.

Test Plan:
- Reset then a single push: source 2 pushes {wid=5,taken=1,dest=0x1000} at cycle 3 -> out_valid=1 at cycle 5 with the same fields; out_valid=0 at cycle 6.
- Fairness: all 4 sources push one entry in the same cycle t (dest=0x10,0x20,0x30,0x40) -> outputs in order src0,1,2,3 at cycles t+2..t+5; overflow=0.
- RR rotation: the last grant was src1 and src0/src1 both push at t -> src0 is served at t+2 (the first candidate after pointer 1, wrapping), then src1 at t+3.
- Full/credit (DEPTH=2):
  - Src3 pushes in 4 consecutive cycles while src0..2 keep their FIFOs non-empty -> in_ready[3] falls to 0 after 2 pushes; the 3rd push is dropped and overflow[3]=1 sticks.
  - Only the accepted entries appear at the output, in order.
- Reset mid-stream: 3 entries queued, reset for 1 cycle -> out_valid stays 0 afterwards, overflow=0, in_ready=all 1, and no stale entry is delivered on a subsequent idle run of 10 cycles.
- Sustained load: random pushes gated by in_ready for 10k cycles -> a scoreboard matches every accepted entry exactly once in per-source order, and no source waits more than NUM_REQS cycles at the head.
